// File: rtl/sha2_round_engine.sv
// SHA-256/SHA-224 compression engine: one 512-bit block per job, UNROLL rounds per clock,
// internal chaining digest with feed-forward add on completion.
module sha2_round_engine #(
    parameter int UNROLL = 1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         START,
    input  logic         FIRST,
    input  logic         MODE,
    input  logic [511:0] BLK_IN,
    output logic         READY,
    output logic         DONE,
    output logic [255:0] DIGEST
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("sha2_round_engine: UNROLL must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FINAL = 2'd2} state_t;

    localparam logic [255:0] IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    state_t       state_q, state_d;
    logic [6:0]   rc_q, rc_d;
    logic [31:0]  wv_q [8];
    logic [31:0]  wv_d [8];
    logic [31:0]  hv_q [8];
    logic [31:0]  hv_d [8];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [255:0] digest_q, digest_d;
    logic         done_q, done_d;
    logic         ready_q, ready_d;

    logic [255:0] chain_s;
    logic [31:0]  ext_s [16+UNROLL];
    logic [31:0]  rv_s [UNROLL+1][8];
    logic [31:0]  t1_s [UNROLL];
    logic [31:0]  t2_s [UNROLL];

    assign chain_s = FIRST ? (MODE ? IV_224 : IV_256) : digest_q;

    // Round datapath: extends the schedule window by UNROLL words and chains UNROLL rounds.
    always_comb begin
        for (int j = 0; j < 16; j++) ext_s[j] = w_q[j];
        for (int u = 0; u < UNROLL; u++) begin
            ext_s[16+u] = small_sigma1(ext_s[14+u]) + ext_s[9+u] + small_sigma0(ext_s[1+u]) + ext_s[u];
        end
        rv_s[0] = wv_q;
        for (int u = 0; u < UNROLL; u++) begin
            t1_s[u] = rv_s[u][7] + big_sigma1(rv_s[u][4])
                    + ((rv_s[u][4] & rv_s[u][5]) ^ (~rv_s[u][4] & rv_s[u][6]))
                    + K[rc_q[5:0] + 6'(u)] + ext_s[u];
            t2_s[u] = big_sigma0(rv_s[u][0])
                    + ((rv_s[u][0] & rv_s[u][1]) ^ (rv_s[u][0] & rv_s[u][2]) ^ (rv_s[u][1] & rv_s[u][2]));
            rv_s[u+1][0] = t1_s[u] + t2_s[u];
            rv_s[u+1][1] = rv_s[u][0];
            rv_s[u+1][2] = rv_s[u][1];
            rv_s[u+1][3] = rv_s[u][2];
            rv_s[u+1][4] = rv_s[u][3] + t1_s[u];
            rv_s[u+1][5] = rv_s[u][4];
            rv_s[u+1][6] = rv_s[u][5];
            rv_s[u+1][7] = rv_s[u][6];
        end
    end

    // Next-state logic for the control FSM, datapath registers and outputs.
    always_comb begin
        state_d  = state_q;
        rc_d     = rc_q;
        wv_d     = wv_q;
        hv_d     = hv_q;
        w_d      = w_q;
        digest_d = digest_q;
        done_d   = 1'b0;
        ready_d  = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    for (int i = 0; i < 8; i++) begin
                        hv_d[i] = chain_s[255-32*i -: 32];
                        wv_d[i] = chain_s[255-32*i -: 32];
                    end
                    for (int j = 0; j < 16; j++) w_d[j] = BLK_IN[511-32*j -: 32];
                    rc_d    = 7'd0;
                    state_d = ST_RUN;
                    ready_d = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                wv_d = rv_s[UNROLL];
                for (int j = 0; j < 16; j++) w_d[j] = ext_s[j+UNROLL];
                rc_d = rc_q + 7'(UNROLL);
                if (rc_q == 7'(64 - UNROLL)) begin
                    state_d = ST_FINAL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = hv_q[i] + wv_q[i];
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            rc_q     <= 7'd0;
            digest_q <= 256'd0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                wv_q[i] <= 32'd0;
                hv_q[i] <= 32'd0;
            end
            for (int j = 0; j < 16; j++) w_q[j] <= 32'd0;
        end else begin
            state_q  <= state_d;
            rc_q     <= rc_d;
            digest_q <= digest_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            wv_q     <= wv_d;
            hv_q     <= hv_d;
            w_q      <= w_d;
        end
    end

    assign READY  = ready_q;
    assign DONE   = done_q;
    assign DIGEST = digest_q;

endmodule
